i2s_tx_fetch: RTL and testbench

Downstream consumer of the two-channel resampler: pulls one left and one right 24-bit sample per 48 kHz frame through the resampler's per-channel pop/ack handshake and serialises them as a standard I2S stream to the DAC. The I2S timing is derived from the 24.576 MHz system clock:

- BCK = clk/8 (64·fs).
- LRCK = clk/512 (fs).

Sits directly after the resampler's `pop_i`/`ack_o`/`data_o` port and is the last block before the DAC pins.

---
 rtl/i2s_tx_fetch.sv | 123 ++++++++++++
 tb/tb_i2s_tx_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_fetch.sv
// I2S transmitter: pops one L/R sample per 48 kHz frame from the resampler and serialises them (BCK=clk/8, LRCK=clk/512).
// Build macro I2S_TX_UNDERRUN_HOLD_EN: on underrun hold the previous sample instead of muting.
module i2s_tx_fetch #(
  parameter int POP_AT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [1:0]  pop_o,
  input  logic [1:0]  ack_i,
  input  logic [23:0] data_i,
  output logic        bck_o,
  output logic        lrck_o,
  output logic        sdata_o,
  output logic        underrun_o
);
  localparam logic [8:0] POP_L = 9'(POP_AT);
  localparam logic [8:0] POP_R = 9'(POP_AT + 1);

  logic [8:0]        r_cnt;
  logic              r_run;
  logic              r_first;
  logic [1:0]        r_pend;
  logic [1:0]        r_val;
  logic [1:0][23:0]  r_next;
  logic [1:0][23:0]  r_out;
  logic              r_sdata;
  logic              r_underrun;

  logic              w_load;
  logic [1:0]        w_pop;
  logic [1:0]        w_ur;
  logic [8:0]        w_cnt_nxt;
  logic [1:0][23:0]  w_out_nxt;
  logic [4:0]        w_k_nxt;
  logic [23:0]       w_sh_nxt;
  logic              w_sd_nxt;

  // r_run gates pops so nothing is requested in the idle cycle at cnt 0 after reset/enable
  always_comb begin
    w_load    = r_run && (r_cnt == 9'd511);
    w_pop[0]  = r_run && (r_cnt == POP_L) && !r_pend[0] && !r_val[0];
    w_pop[1]  = r_run && (r_cnt == POP_R) && !r_pend[1] && !r_val[1];
    w_cnt_nxt = r_cnt + 9'd1;
    w_out_nxt = r_out;
    w_ur      = 2'b00;
    for (int c = 0; c < 2; c++) begin
      if (w_load) begin
        if (r_val[c]) begin
          w_out_nxt[c] = r_next[c];
        end else begin
          w_ur[c] = 1'b1;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
          w_out_nxt[c] = r_out[c];
`else
          w_out_nxt[c] = 24'd0;
`endif
        end
      end
    end
    // Serial bit is registered one cycle ahead so it changes together with BCK falling
    w_k_nxt  = w_cnt_nxt[7:3];
    w_sh_nxt = w_cnt_nxt[8] ? w_out_nxt[1] : w_out_nxt[0];
    w_sd_nxt = 1'b0;
    if (w_k_nxt >= 5'd1 && w_k_nxt <= 5'd24) begin
      w_sd_nxt = w_sh_nxt[5'd24 - w_k_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= 9'd0;
      r_run      <= 1'b0;
      r_first    <= 1'b1;
      r_pend     <= 2'b00;
      r_val      <= 2'b00;
      r_next     <= '0;
      r_out      <= '0;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
    end else if (!en_i) begin
      r_cnt      <= 9'd0;
      r_run      <= 1'b0;
      r_first    <= 1'b1;
      r_pend     <= 2'b00;
      r_val      <= 2'b00;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_run      <= 1'b1;
      r_out      <= w_out_nxt;
      r_underrun <= (|w_ur) && !r_first;
      if (w_load) begin
        r_first <= 1'b0;
      end
      if (w_cnt_nxt[2:0] == 3'd0) begin
        r_sdata <= w_sd_nxt;
      end
      // A pending request survives the load so a late ack feeds the next frame
      for (int c = 0; c < 2; c++) begin
        if (w_load) begin
          r_val[c] <= 1'b0;
        end
        if (w_pop[c]) begin
          r_pend[c] <= 1'b1;
        end
        if (ack_i[c]) begin
          r_next[c] <= data_i;
          r_val[c]  <= 1'b1;
          r_pend[c] <= 1'b0;
        end
      end
    end
  end

  assign pop_o      = w_pop;
  assign bck_o      = r_cnt[2];
  assign lrck_o     = r_cnt[8];
  assign sdata_o    = r_sdata;
  assign underrun_o = r_underrun;

endmodule

// File: tb/tb_i2s_tx_fetch.sv
// Directed bench for i2s_tx_fetch: resampler model acks 40 clocks after each pop; whole frames are captured and compared.
module tb_i2s_tx_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_i = 1'b1;
  logic [1:0]  ack_i = 2'b00;
  logic [23:0] data_i = 24'd0;
  logic [1:0]  pop_o;
  logic        bck_o, lrck_o, sdata_o, underrun_o;

  i2s_tx_fetch #(.POP_AT(256)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .pop_o(pop_o), .ack_i(ack_i), .data_i(data_i),
    .bck_o(bck_o), .lrck_o(lrck_o), .sdata_o(sdata_o), .underrun_o(underrun_o)
  );

  always #5 clk = ~clk;

  localparam logic [23:0] SMP_L = 24'h7FFFFF;
  localparam logic [23:0] SMP_R = 24'h800001;

  int n_chk = 0;
  int n_pass = 0;

  logic [8:0] tb_cnt = 9'd0;
  always @(posedge clk) tb_cnt <= (rst && en_i) ? tb_cnt + 9'd1 : 9'd0;

  logic [1:0]  m_en = 2'b11;
  int          dly0 = 0;
  int          dly1 = 0;
  logic        inj_vld = 1'b0;
  logic        inj_ch = 1'b0;
  logic [23:0] inj_dat = 24'd0;

  // Resampler model: answers each pop 40 clocks later; inj_vld adds an extra ack
  always @(negedge clk) begin
    ack_i = 2'b00;
    data_i = 24'd0;
    if (dly0 > 0) begin
      dly0--;
      if (dly0 == 0) begin ack_i[0] = 1'b1; data_i = SMP_L; end
    end
    if (dly1 > 0) begin
      dly1--;
      if (dly1 == 0) begin ack_i[1] = 1'b1; data_i = SMP_R; end
    end
    if (inj_vld) begin ack_i[inj_ch] = 1'b1; data_i = inj_dat; end
    if (pop_o[0] && m_en[0]) dly0 = 40;
    if (pop_o[1] && m_en[1]) dly1 = 40;
  end

  int          f_ur, f_ur_at, f_pop0_n, f_pop1_n, f_pop0_at, f_pop1_at, f_pop_first;
  int          f_both, f_bck_err, f_lr_err, f_sd_err;
  logic [31:0] f_l, f_r;

  function automatic logic [31:0] exp_slot(input logic [23:0] s);
    logic [31:0] v;
    v = 32'd0;
    for (int k = 1; k <= 24; k++) v[k] = s[24-k];
    return v;
  endfunction

  task automatic wait_cnt(input int t);
    int g;
    g = 0;
    while (tb_cnt != t[8:0] && g < 2000) begin @(negedge clk); g++; end
    if (g >= 2000) begin n_chk++; $display("FAIL wait_cnt: counter never reached %0d", t); end
  endtask

  // Captures one frame starting at cnt 0; optional extra ack injected after index inj_at
  task automatic run_frame(input int inj_at, input logic ch, input logic [23:0] dat);
    logic prev;
    wait_cnt(0);
    f_ur = 0; f_ur_at = -1; f_pop0_n = 0; f_pop1_n = 0; f_pop0_at = -1; f_pop1_at = -1;
    f_pop_first = 1000; f_both = 0; f_bck_err = 0; f_lr_err = 0; f_sd_err = 0;
    f_l = 32'd0; f_r = 32'd0;
    prev = sdata_o;
    for (int i = 0; i < 512; i++) begin
      if (i > 0) @(negedge clk);
      if (underrun_o) begin f_ur++; f_ur_at = i; end
      if (pop_o[0]) begin f_pop0_n++; f_pop0_at = i; end
      if (pop_o[1]) begin f_pop1_n++; f_pop1_at = i; end
      if (pop_o != 2'b00 && f_pop_first == 1000) f_pop_first = i;
      if (pop_o == 2'b11) f_both++;
      if (bck_o !== tb_cnt[2]) f_bck_err++;
      if (lrck_o !== tb_cnt[8]) f_lr_err++;
      if ((i % 8) != 0 && sdata_o !== prev) f_sd_err++;
      prev = sdata_o;
      if ((i % 8) == 0) begin
        if (i < 256) f_l[i/8] = sdata_o;
        else f_r[(i-256)/8] = sdata_o;
      end
      if (i == inj_at) begin inj_ch = ch; inj_dat = dat; #1 inj_vld = 1'b1; end
      if (i == inj_at + 1) begin #1 inj_vld = 1'b0; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    inj_ch = 1'b0; inj_dat = 24'hABCDEF;
    #1 inj_vld = 1'b1;
    @(negedge clk);
    #1 inj_vld = 1'b0;
    @(negedge clk);
    n_chk++; if (pop_o !== 2'b00) $display("FAIL rst_pop: got %b want 00", pop_o); else n_pass++;
    n_chk++; if (bck_o !== 1'b0) $display("FAIL rst_bck: got %b want 0", bck_o); else n_pass++;
    n_chk++; if (lrck_o !== 1'b0) $display("FAIL rst_lrck: got %b want 0", lrck_o); else n_pass++;
    n_chk++; if (sdata_o !== 1'b0) $display("FAIL rst_sdata: got %b want 0", sdata_o); else n_pass++;
    n_chk++; if (underrun_o !== 1'b0) $display("FAIL rst_underrun: got %b want 0", underrun_o); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    run_frame(-1, 1'b0, 24'd0);
    n_chk++; if (f_pop0_at !== 256) $display("FAIL pop_left_at: got %0d want 256", f_pop0_at); else n_pass++;
    n_chk++; if (f_pop1_at !== 257) $display("FAIL pop_right_at: got %0d want 257", f_pop1_at); else n_pass++;
    n_chk++; if (f_pop0_n + f_pop1_n !== 2) $display("FAIL pop_count: got %0d want 2", f_pop0_n + f_pop1_n); else n_pass++;
    n_chk++; if (f_pop_first !== 256) $display("FAIL first_pop: got %0d want 256", f_pop_first); else n_pass++;
    n_chk++; if (f_l !== 32'd0) $display("FAIL frame0_left: got %h want 0", f_l); else n_pass++;
    n_chk++; if (f_ur !== 0) $display("FAIL frame0_underrun: got %0d want 0", f_ur); else n_pass++;
    run_frame(-1, 1'b0, 24'd0);
    n_chk++; if (f_l !== exp_slot(SMP_L)) $display("FAIL frame1_left: got %h want %h", f_l, exp_slot(SMP_L)); else n_pass++;
    n_chk++; if (f_r !== exp_slot(SMP_R)) $display("FAIL frame1_right: got %h want %h", f_r, exp_slot(SMP_R)); else n_pass++;
    n_chk++; if (f_ur !== 0) $display("FAIL frame1_underrun: got %0d want 0", f_ur); else n_pass++;
  endtask

  task automatic test_timing();
    int bck_e, lr_e, sd_e, ur, both;
    bck_e = 0; lr_e = 0; sd_e = 0; ur = 0; both = 0;
    for (int f = 0; f < 4; f++) begin
      run_frame(-1, 1'b0, 24'd0);
      bck_e += f_bck_err; lr_e += f_lr_err; sd_e += f_sd_err; ur += f_ur; both += f_both;
    end
    n_chk++; if (bck_e !== 0) $display("FAIL bck_period: got %0d errors want 0", bck_e); else n_pass++;
    n_chk++; if (lr_e !== 0) $display("FAIL lrck_period: got %0d errors want 0", lr_e); else n_pass++;
    n_chk++; if (sd_e !== 0) $display("FAIL sdata_edge: got %0d off-edge changes want 0", sd_e); else n_pass++;
    n_chk++; if (ur !== 0) $display("FAIL steady_underrun: got %0d want 0", ur); else n_pass++;
    n_chk++; if (both !== 0) $display("FAIL pop_overlap: got %0d want 0", both); else n_pass++;
  endtask

  task automatic test_underrun();
    logic [31:0] exp_r;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
    exp_r = exp_slot(SMP_R);
`else
    exp_r = 32'd0;
`endif
    m_en[1] = 1'b0;
    run_frame(-1, 1'b0, 24'd0);
    n_chk++; if (f_pop1_n !== 1) $display("FAIL ur_pop_issued: got %0d want 1", f_pop1_n); else n_pass++;
    run_frame(300, 1'b1, 24'h5A5A5A);
    n_chk++; if (f_ur !== 1) $display("FAIL ur_count: got %0d want 1", f_ur); else n_pass++;
    n_chk++; if (f_ur_at !== 0) $display("FAIL ur_at: got %0d want 0", f_ur_at); else n_pass++;
    n_chk++; if (f_pop1_n !== 0) $display("FAIL ur_no_repop: got %0d want 0", f_pop1_n); else n_pass++;
    n_chk++; if (f_r !== exp_r) $display("FAIL ur_right_slot: got %h want %h", f_r, exp_r); else n_pass++;
    n_chk++; if (f_l !== exp_slot(SMP_L)) $display("FAIL ur_left_slot: got %h want %h", f_l, exp_slot(SMP_L)); else n_pass++;
    m_en[1] = 1'b1;
    run_frame(-1, 1'b0, 24'd0);
    n_chk++; if (f_r !== exp_slot(24'h5A5A5A)) $display("FAIL late_ack_out: got %h want %h", f_r, exp_slot(24'h5A5A5A)); else n_pass++;
    n_chk++; if (f_ur !== 0) $display("FAIL late_ack_underrun: got %0d want 0", f_ur); else n_pass++;
    n_chk++; if (f_pop1_n !== 1) $display("FAIL late_ack_repop: got %0d want 1", f_pop1_n); else n_pass++;
  endtask

  task automatic test_unsolicited();
    run_frame(400, 1'b0, 24'h000123);
    n_chk++; if (f_l !== exp_slot(SMP_L)) $display("FAIL unsol_same_frame: got %h want %h", f_l, exp_slot(SMP_L)); else n_pass++;
    run_frame(-1, 1'b0, 24'd0);
    n_chk++; if (f_l !== exp_slot(24'h000123)) $display("FAIL unsol_left: got %h want %h", f_l, exp_slot(24'h000123)); else n_pass++;
    n_chk++; if (f_r !== exp_slot(SMP_R)) $display("FAIL unsol_right: got %h want %h", f_r, exp_slot(SMP_R)); else n_pass++;
    n_chk++; if (f_pop0_n !== 1) $display("FAIL unsol_pop: got %0d want 1", f_pop0_n); else n_pass++;
  endtask

  task automatic test_reset_mid();
    m_en[1] = 1'b0;
    wait_cnt(300);
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (pop_o !== 2'b00) $display("FAIL midrst_pop: got %b want 00", pop_o); else n_pass++;
    n_chk++; if (lrck_o !== 1'b0) $display("FAIL midrst_lrck: got %b want 0", lrck_o); else n_pass++;
    n_chk++; if (bck_o !== 1'b0) $display("FAIL midrst_bck: got %b want 0", bck_o); else n_pass++;
    n_chk++; if (sdata_o !== 1'b0) $display("FAIL midrst_sdata: got %b want 0", sdata_o); else n_pass++;
    m_en = 2'b11;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_frame(-1, 1'b0, 24'd0);
    n_chk++; if (f_pop_first !== 256) $display("FAIL midrst_first_pop: got %0d want 256", f_pop_first); else n_pass++;
    n_chk++; if (f_pop1_n !== 1) $display("FAIL midrst_pend_cleared: got %0d want 1", f_pop1_n); else n_pass++;
    n_chk++; if (f_l !== 32'd0) $display("FAIL midrst_left_zero: got %h want 0", f_l); else n_pass++;
    n_chk++; if (f_r !== 32'd0) $display("FAIL midrst_right_zero: got %h want 0", f_r); else n_pass++;
  endtask

  task automatic test_enable();
    int ur;
    ur = 0;
    wait_cnt(400);
    en_i = 1'b0;
    @(negedge clk);
    n_chk++; if (lrck_o !== 1'b0) $display("FAIL dis_lrck: got %b want 0", lrck_o); else n_pass++;
    n_chk++; if (sdata_o !== 1'b0) $display("FAIL dis_sdata: got %b want 0", sdata_o); else n_pass++;
    n_chk++; if (pop_o !== 2'b00) $display("FAIL dis_pop: got %b want 00", pop_o); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (underrun_o || bck_o) ur++;
    end
    n_chk++; if (ur !== 0) $display("FAIL dis_idle: got %0d active cycles want 0", ur); else n_pass++;
    m_en[1] = 1'b0;
    en_i = 1'b1;
    run_frame(-1, 1'b0, 24'd0);
    n_chk++; if (f_pop_first !== 256) $display("FAIL en_first_pop: got %0d want 256", f_pop_first); else n_pass++;
    n_chk++; if (f_pop1_n !== 1) $display("FAIL en_pend_cleared: got %0d want 1", f_pop1_n); else n_pass++;
    run_frame(-1, 1'b0, 24'd0);
    n_chk++; if (f_ur !== 0) $display("FAIL en_first_load_quiet: got %0d want 0", f_ur); else n_pass++;
    n_chk++; if (f_l !== exp_slot(SMP_L)) $display("FAIL en_left: got %h want %h", f_l, exp_slot(SMP_L)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timing();
    test_underrun();
    test_unsolicited();
    test_reset_mid();
    test_enable();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
